fpu_arbiter: RTL

//  Shares the single-cycle-combinational FPU between two requesters (s0, s1) with

---
 rtl/fpu_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin two-requester front end for a shared combinational FPU.
// Ports: s0_*/s1_* commands in, rsp_* response out, fpu_* to/from the FPU, busy.
module fpu_arbiter #(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 2,
  parameter int TAG_W       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_a,
  input  logic [DATA_W-1:0] s0_b,
  input  logic [OP_W-1:0]   s0_op,
  input  logic [TAG_W-1:0]  s0_tag,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_a,
  input  logic [DATA_W-1:0] s1_b,
  input  logic [OP_W-1:0]   s1_op,
  input  logic [TAG_W-1:0]  s1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [6:0]        rsp_flags,
  output logic              rsp_src,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  output logic [OP_W-1:0]   fpu_op,
  input  logic [DATA_W-1:0] fpu_o,
  input  logic [6:0]        fpu_flags,
  output logic              busy
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [OP_W-1:0] OP_NOP = '1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              src_q, src_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [6:0]        flg_q, flg_d;

  logic g0, g1, acc0, acc1, is_nop;

  // Contention goes to whoever was not served last.
  assign g0 = s0_valid && (!s1_valid || last_q);
  assign g1 = s1_valid && (!s0_valid || !last_q);

  assign s0_ready = (state_q == IDLE) && g0;
  assign s1_ready = (state_q == IDLE) && g1;
  assign acc0     = s0_valid && s0_ready;
  assign acc1     = s1_valid && s1_ready;
  assign is_nop   = (op_q == OP_NOP);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    src_d   = src_q;
    tag_d   = tag_q;
    res_d   = res_q;
    flg_d   = flg_q;
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          acc0: begin
            a_d     = s0_a;
            b_d     = s0_b;
            op_d    = s0_op;
            tag_d   = s0_tag;
            src_d   = 1'b0;
            last_d  = 1'b0;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = EXEC;
          end
          acc1: begin
            a_d     = s1_a;
            b_d     = s1_b;
            op_d    = s1_op;
            tag_d   = s1_tag;
            src_d   = 1'b1;
            last_d  = 1'b1;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = EXEC;
          end
          default: ;
        endcase
      end
      EXEC: begin
        if (cnt_q == '0) begin
          // FPU leaves O stale on NOP, so report a clean zero.
          res_d   = is_nop ? '0 : fpu_o;
          flg_d   = fpu_flags | (is_nop ? 7'h40 : 7'h00);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          op_d    = OP_NOP;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
      src_q   <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign fpu_op     = op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = res_q;
  assign rsp_flags  = flg_q;
  assign rsp_src    = src_q;
  assign rsp_tag    = tag_q;
  assign busy       = (state_q != IDLE);

endmodule
